// File: rtl/spi_xfer_scheduler.sv
// APB master that configures an SPI slave once, then serves two requesters
// round-robin: write data, wait for the SPI interrupt, read the received byte.
module spi_xfer_scheduler #(
  parameter logic [7:0] CTRL_VAL = 8'hB7,
  parameter logic [7:0] BAUD_VAL = 8'h84,
  parameter int         TIMEOUT  = 255
) (
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic [1:0] req_i,
  input  logic [7:0] req0_data_i,
  input  logic [7:0] req1_data_i,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic [7:0] rdata_o,
  output logic       err_o,
  output logic       PSEL_o,
  output logic       PENABLE_o,
  output logic       PWRITE_o,
  output logic [2:0] PADDR_o,
  output logic [7:0] PWDATA_o,
  input  logic [7:0] PRDATA_i,
  input  logic       PREADY_i,
  input  logic       PSLVERR_i,
  input  logic       spi_irq_i
);

  typedef enum logic [2:0] {
    CFG_CTRL,
    CFG_BAUD,
    IDLE,
    WR_DATA,
    WAIT_IRQ,
    RD_DATA,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_n;
  logic       acc_q, acc_n;
  logic       run_q;
  logic [7:0] cnt_q, cnt_n;
  logic [1:0] gnt_q, gnt_n;
  logic       ptr_q, ptr_n;
  logic [7:0] wdata_q, wdata_n;
  logic [7:0] rdata_q, rdata_n;
  logic       err_q, err_n;

  logic       apb;
  logic       fin;
  logic [1:0] pick;

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q <= CFG_CTRL;
      acc_q   <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= 8'd0;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      run_q   <= 1'b1;
      cnt_q   <= cnt_n;
      gnt_q   <= gnt_n;
      ptr_q   <= ptr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  // run_q holds off the first SETUP so the bus is idle while in reset
  assign apb = run_q &&
               (state_q == CFG_CTRL || state_q == CFG_BAUD ||
                state_q == WR_DATA  || state_q == RD_DATA);
  assign fin = acc_q & PREADY_i;

  always_comb begin
    pick = 2'b00;
    if (req_i == 2'b11) pick = ptr_q ? 2'b10 : 2'b01;
    else                pick = req_i;
  end

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    gnt_n   = gnt_q;
    ptr_n   = ptr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    if (apb) begin
      if (!acc_q)        acc_n = 1'b1;
      else if (PREADY_i) acc_n = 1'b0;
    end
    unique case (state_q)
      CFG_CTRL: begin
        if (fin) state_n = PSLVERR_i ? CFG_CTRL : CFG_BAUD;
      end
      CFG_BAUD: begin
        if (fin) state_n = PSLVERR_i ? CFG_CTRL : IDLE;
      end
      IDLE: begin
        if (|req_i) begin
          gnt_n   = pick;
          wdata_n = pick[1] ? req1_data_i : req0_data_i;
          ptr_n   = pick[0];
          err_n   = 1'b0;
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (fin) begin
          if (PSLVERR_i) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            cnt_n   = 8'd0;
            state_n = WAIT_IRQ;
          end
        end
      end
      WAIT_IRQ: begin
        if (spi_irq_i) begin
          state_n = RD_DATA;
        end else if (cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      RD_DATA: begin
        if (fin) begin
          if (PSLVERR_i) err_n = 1'b1;
          else           rdata_n = PRDATA_i;
          state_n = DONE;
        end
      end
      DONE: begin
        gnt_n   = 2'b00;
        state_n = IDLE;
      end
      default: state_n = CFG_CTRL;
    endcase
  end

  always_comb begin
    PADDR_o  = 3'b000;
    PWDATA_o = 8'd0;
    if (apb) begin
      unique case (state_q)
        CFG_CTRL: PWDATA_o = CTRL_VAL;
        CFG_BAUD: begin
          PADDR_o  = 3'b010;
          PWDATA_o = BAUD_VAL;
        end
        WR_DATA: begin
          PADDR_o  = 3'b101;
          PWDATA_o = wdata_q;
        end
        RD_DATA: PADDR_o = 3'b101;
        default: PADDR_o = 3'b000;
      endcase
    end
  end

  assign PSEL_o    = apb;
  assign PENABLE_o = apb & acc_q;
  assign PWRITE_o  = apb & (state_q != RD_DATA);
  assign gnt_o     = (state_q == IDLE) ? pick : gnt_q;
  assign done_o    = (state_q == DONE) ? gnt_q : 2'b00;
  assign err_o     = (state_q == DONE) & err_q;
  assign rdata_o   = rdata_q;

endmodule

// File: doc/spi_xfer_scheduler.md
SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 Parameter: CTRL_VAL, default 8'hB7, value written to the SPI control register (addr 3'b000) during configuration.
REQ-002 Parameter: BAUD_VAL, default 8'h84, value written to the SPI baud register (addr 3'b010) during configuration.
REQ-003 Parameter: TIMEOUT, default 255, maximum number of PCLK cycles to wait for the SPI interrupt (8-bit counter).
REQ-004 PCLK  input  1  single clock; all state updates on the rising edge.
REQ-005 PRESET_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  2  transfer request, one bit per requester; level, held until done_o for that requester.
REQ-007 req0_data_i, req1_data_i  input  8 each  byte to transmit for requester 0 and requester 1.
REQ-008 gnt_o  output  2  one-hot grant to the requester currently being served.
REQ-009 done_o  output  2  one-cycle pulse to the served requester when its transfer ends.
REQ-010 rdata_o  output  8  received byte, valid in the done_o cycle and held until the next done_o.
REQ-011 err_o  output  1  qualifies done_o: transfer failed (PSLVERR or timeout).
REQ-012 PSEL_o, PENABLE_o, PWRITE_o  output  1 each  APB master controls toward the SPI slave.
REQ-013 PADDR_o  output  3  APB address; PWDATA_o  output  8  APB write data.
REQ-014 PRDATA_i  input  8; PREADY_i  input  1; PSLVERR_i  input  1  APB slave responses.
REQ-015 spi_irq_i  input  1  SPI interrupt request (transfer complete).

Function
REQ-016 The block SHALL sequence the APB-SPI slave: one-time configuration, then per-request write of data register (3'b101), wait for spi_irq_i, read of data register (3'b101).
REQ-017 States SHALL be: CFG_CTRL, CFG_BAUD, IDLE, WR_DATA, WAIT_IRQ, RD_DATA, DONE.
REQ-018 Each APB transfer SHALL be: one SETUP cycle (PSEL_o=1, PENABLE_o=0), then ACCESS cycles (PSEL_o=1, PENABLE_o=1) until PREADY_i=1 is sampled; PADDR_o/PWRITE_o/PWDATA_o SHALL stay stable across SETUP and ACCESS.
REQ-019 After reset the FSM SHALL enter CFG_CTRL (write CTRL_VAL to 3'b000), then CFG_BAUD (write BAUD_VAL to 3'b010), then IDLE; requests SHALL NOT be granted before configuration completes.
REQ-020 PSLVERR_i sampled with PREADY_i during configuration SHALL restart configuration at CFG_CTRL.
REQ-021 In IDLE with any req_i bit set, the FSM SHALL grant one requester via round-robin (priority to the requester not served last; requester 0 wins first after reset) and enter WR_DATA the next cycle.
REQ-022 gnt_o SHALL be asserted from the grant cycle through the done_o cycle and SHALL be one-hot or zero.
REQ-023 WR_DATA SHALL write the granted requester's data byte, latched at grant, to 3'b101; then enter WAIT_IRQ.
REQ-024 WAIT_IRQ SHALL count PCLK cycles from 0; spi_irq_i=1 enters RD_DATA; count reaching TIMEOUT without spi_irq_i enters DONE with err_o=1.
REQ-025 RD_DATA SHALL read 3'b101 and capture PRDATA_i into rdata_o on the PREADY_i cycle; then enter DONE.
REQ-026 PSLVERR_i with PREADY_i in WR_DATA or RD_DATA SHALL abort to DONE with err_o=1; rdata_o unchanged.
REQ-027 DONE SHALL last exactly one cycle: done_o pulses for the granted bit, gnt_o then clears, FSM returns to IDLE.
REQ-028 A requester dropping req_i mid-transfer SHALL NOT abort the transfer.
REQ-029 Minimum request-to-done latency with zero-wait APB and immediate IRQ: grant 1 + write 2 + wait 1 + read 2 + done 1 = 7 cycles.
REQ-030 Outside an APB transfer PSEL_o and PENABLE_o SHALL be 0.

Reset
REQ-031 On PRESET_n=0, asynchronously: state=CFG_CTRL, PSEL_o=0, PENABLE_o=0, PWRITE_o=0, PADDR_o=0, PWDATA_o=0, gnt_o=0, done_o=0, rdata_o=0, err_o=0, timeout counter=0, round-robin pointer=requester 0.
REQ-032 Reset asserted mid-transfer SHALL abandon it without done_o; reconfiguration follows deassertion.

Verification
REQ-033 Reset release, PREADY_i=1 -> APB writes 3'b000<=8'hB7 then 3'b010<=8'h84, each SETUP+ACCESS, before any gnt_o.
REQ-034 req_i=2'b01, data 8'hAA, irq after 20 cycles, PRDATA_i=8'h5C -> write 3'b101<=8'hAA, read 3'b101, done_o=2'b01, rdata_o=8'h5C, err_o=0.
REQ-035 req_i=2'b11 held -> grants alternate 01,10,01; no overlap of gnt_o.
REQ-036 PREADY_i held low 3 ACCESS cycles on write -> PSEL_o/PENABLE_o/PADDR_o stable for all 3, transfer completes.
REQ-037 spi_irq_i never asserted -> done_o with err_o=1 after 255 WAIT_IRQ cycles; no read issued.
REQ-038 PSLVERR_i=1 on data write -> done_o with err_o=1, no WAIT_IRQ; PRESET_n pulsed in WAIT_IRQ -> outputs zero immediately, configuration repeats.
